// File: rtl/sram_scan_if.sv
// sram_scan_if: scan-chain pads and SRAM port bundle between the GPIO mux and the scan controller
interface sram_scan_if #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int WMASK_WIDTH = 4
);
   logic                   scan_en;
   logic                   scan_in;
   logic                   sram_load;
   logic                   global_csb;
   logic                   scan_out;
   logic                   sram_csb;
   logic                   sram_web;
   logic [WMASK_WIDTH-1:0] sram_wmask;
   logic [ADDR_WIDTH-1:0]  sram_addr;
   logic [DATA_WIDTH-1:0]  sram_din;
   logic [DATA_WIDTH-1:0]  sram_dout;
   logic                   busy;
   logic                   done;
   logic                   mismatch;
   modport slave (
      input  scan_en, scan_in, sram_load, global_csb, sram_dout,
      output scan_out, sram_csb, sram_web, sram_wmask, sram_addr, sram_din, busy, done, mismatch
   );
   modport master (
      output scan_en, scan_in, sram_load, global_csb, sram_dout,
      input  scan_out, sram_csb, sram_web, sram_wmask, sram_addr, sram_din, busy, done, mismatch
   );
endinterface

// File: rtl/sram_scan_ctrl.sv
// sram_scan_ctrl: serial command chain that launches one SRAM access per load edge; SRAM_SCAN_CHECK_EN adds sticky read compare
module sram_scan_ctrl #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int WMASK_WIDTH  = 4,
   parameter int READ_LATENCY = 1
) (
   input logic        clk,
   input logic        resetn,
   sram_scan_if.slave bus
);
   localparam int W       = ADDR_WIDTH + DATA_WIDTH + WMASK_WIDTH + 2;
   localparam int DIN_LSB = WMASK_WIDTH + 2;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_e;
   state_e                 state_q, state_d;
   logic [W-1:0]           chain_q, chain_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   load_q;
   logic                   csb_q, csb_d, web_q, web_d;
   logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  din_q, din_d;
   logic                   load_edge, is_read;
`ifdef SRAM_SCAN_CHECK_EN
   logic                   mis_q, mis_d;
`endif
   assign load_edge = bus.sram_load & ~load_q;
   assign is_read   = ~chain_q[0] & chain_q[1];
   // State, chain and SRAM-port registers; reset leaves the SRAM deselected
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         chain_q <= '0;
         cnt_q   <= '0;
         load_q  <= 1'b0;
         csb_q   <= 1'b1;
         web_q   <= 1'b1;
         wmask_q <= '0;
         addr_q  <= '0;
         din_q   <= '0;
`ifdef SRAM_SCAN_CHECK_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         chain_q <= chain_d;
         cnt_q   <= cnt_d;
         load_q  <= bus.sram_load;
         csb_q   <= csb_d;
         web_q   <= web_d;
         wmask_q <= wmask_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
`ifdef SRAM_SCAN_CHECK_EN
         mis_q   <= mis_d;
`endif
      end
   end
   // Shift only in IDLE, latch the chain onto the SRAM port at launch, capture read data at the end
   always_comb begin
      state_d = state_q;
      chain_d = chain_q;
      cnt_d   = cnt_q;
      csb_d   = csb_q;
      web_d   = web_q;
      wmask_d = wmask_q;
      addr_d  = addr_q;
      din_d   = din_q;
`ifdef SRAM_SCAN_CHECK_EN
      mis_d   = mis_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.scan_en) begin
               chain_d = {chain_q[W-2:0], bus.scan_in};
            end else if (load_edge && !bus.global_csb) begin
               state_d = ISSUE;
               csb_d   = chain_q[0] | bus.global_csb;
               web_d   = chain_q[1];
               wmask_d = chain_q[DIN_LSB-1:2];
               din_d   = chain_q[DIN_LSB +: DATA_WIDTH];
               addr_d  = chain_q[W-1 -: ADDR_WIDTH];
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = 4'd1;
         end
         WAIT: begin
            state_d = (cnt_q == 4'(READ_LATENCY)) ? CAPTURE : WAIT;
            cnt_d   = cnt_q + 4'd1;
         end
         CAPTURE: begin
            state_d = IDLE;
            csb_d   = 1'b1;
            web_d   = 1'b1;
            if (is_read) chain_d[DIN_LSB +: DATA_WIDTH] = bus.sram_dout;
`ifdef SRAM_SCAN_CHECK_EN
            mis_d = mis_q | (is_read && bus.sram_dout != chain_q[DIN_LSB +: DATA_WIDTH]);
`endif
         end
      endcase
   end
   assign bus.scan_out   = chain_q[W-1];
   assign bus.sram_csb   = csb_q;
   assign bus.sram_web   = web_q;
   assign bus.sram_wmask = wmask_q;
   assign bus.sram_addr  = addr_q;
   assign bus.sram_din   = din_q;
   assign bus.busy       = state_q != IDLE;
   assign bus.done       = state_q == CAPTURE;
`ifdef SRAM_SCAN_CHECK_EN
   assign bus.mismatch   = mis_q;
`else
   assign bus.mismatch   = 1'b0;
`endif
endmodule

// File: tb/tb_sram_scan_ctrl.sv
// tb_sram_scan_ctrl: scoreboard bench for sram_scan_ctrl with a byte-masked SRAM model
module tb_sram_scan_ctrl;
   localparam int LAT = 1;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   logic [53:0] exp_q[$];
   logic [31:0] mem [0:255] = '{default: 32'h0};
   sram_scan_if bus ();
   sram_scan_ctrl #(.READ_LATENCY(LAT)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   always #5 clk = ~clk;
   // SRAM model: byte-masked write, registered read data that holds between reads
   always @(posedge clk) begin
      if (!bus.sram_csb) begin
         if (!bus.sram_web) begin
            for (int b = 0; b < 4; b++)
               if (bus.sram_wmask[b]) mem[bus.sram_addr[7:0]][8*b +: 8] <= bus.sram_din[8*b +: 8];
         end else bus.sram_dout <= mem[bus.sram_addr[7:0]];
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end
   function automatic logic [53:0] pk(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m, input logic web, input logic csb);
      return {a, d, m, web, csb};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic shift_in(input logic [53:0] p);
      for (int i = 53; i >= 0; i--) begin
         bus.scan_en = 1'b1;
         bus.scan_in = p[i];
         tick();
      end
      bus.scan_en = 1'b0;
      bus.scan_in = 1'b0;
   endtask
   task automatic shift_out(output logic [53:0] got);
      for (int i = 53; i >= 0; i--) begin
         got[i] = bus.scan_out;
         bus.scan_en = 1'b1;
         bus.scan_in = 1'b0;
         tick();
      end
      bus.scan_en = 1'b0;
   endtask
   // Launch one access; optionally hammer scan_en while busy; returns cycles to done and sram_csb in ISSUE
   task automatic access(input bit jam, output int cyc, output logic csb_issue);
      bus.sram_load = 1'b1;
      tick();
      bus.sram_load = 1'b0;
      csb_issue = bus.sram_csb;
      cyc = 1;
      bus.scan_en = jam;
      bus.scan_in = jam;
      while (!bus.done && cyc < 40) begin
         tick();
         cyc++;
      end
      tick();
      bus.scan_en = 1'b0;
      bus.scan_in = 1'b0;
   endtask
   task automatic test_reset();
      bus.scan_en = 0; bus.scan_in = 0; bus.sram_load = 0; bus.global_csb = 0;
      resetn = 1'b0;
      tick(); tick();
      resetn = 1'b1;
      tick();
      n_checks++;
      if (bus.scan_out !== 1'b0 || bus.sram_csb !== 1'b1 || bus.sram_web !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mismatch !== 1'b0 || bus.sram_addr !== 16'h0 || bus.sram_din !== 32'h0 || bus.sram_wmask !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_state: got out=%b csb=%b web=%b busy=%b done=%b mis=%b addr=%h din=%h wm=%h, required 0 1 1 0 0 0 0 0 0",
                  bus.scan_out, bus.sram_csb, bus.sram_web, bus.busy, bus.done, bus.mismatch, bus.sram_addr, bus.sram_din, bus.sram_wmask);
      end
      shift_in({54{1'b1}});
      n_checks++;
      if (bus.scan_out !== 1'b1) begin n_fail++; $display("FAIL shift_ones: scan_out got %b required 1", bus.scan_out); end
      bus.scan_en = 1'b1;
      bus.scan_in = 1'b1;
      tick();
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if (bus.scan_out !== 1'b0 || bus.sram_csb !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_shift: got out=%b csb=%b busy=%b, required 0 1 0", bus.scan_out, bus.sram_csb, bus.busy);
      end
      bus.scan_en = 1'b0;
      bus.scan_in = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
   endtask
   task automatic test_write();
      shift_in(pk(16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0));
      n_checks++;
      if (bus.scan_out !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL write_preload: out=%b busy=%b required 0 0", bus.scan_out, bus.busy); end
      bus.sram_load = 1'b1;
      tick();
      bus.sram_load = 1'b0;
      for (int c = 1; c <= LAT + 2; c++) begin
         n_checks++;
         if (bus.sram_csb !== 1'b0 || bus.sram_web !== 1'b0 || bus.sram_addr !== 16'h0010 || bus.sram_din !== 32'hDEADBEEF || bus.sram_wmask !== 4'hF || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_port_c%0d: got csb=%b web=%b addr=%h din=%h wm=%h busy=%b, required 0 0 0010 deadbeef f 1",
                     c, bus.sram_csb, bus.sram_web, bus.sram_addr, bus.sram_din, bus.sram_wmask, bus.busy);
         end
         n_checks++;
         if (bus.done !== (c == LAT + 2)) begin n_fail++; $display("FAIL write_done_c%0d: got %b required %b", c, bus.done, c == LAT + 2); end
         tick();
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.sram_csb !== 1'b1 || bus.sram_web !== 1'b1 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL write_end: got busy=%b csb=%b web=%b done=%b, required 0 1 1 0", bus.busy, bus.sram_csb, bus.sram_web, bus.done);
      end
   endtask
   task automatic test_readback();
      int cyc; logic c1; logic [53:0] got, e;
      shift_in(pk(16'h0010, 32'hDEADBEEF, 4'h0, 1'b1, 1'b0));
      exp_q.push_back(pk(16'h0010, 32'hDEADBEEF, 4'h0, 1'b1, 1'b0));
      access(1'b0, cyc, c1);
      n_checks++;
      if (cyc !== LAT + 2 || c1 !== 1'b0) begin n_fail++; $display("FAIL read_latency: got cyc=%0d csb=%b required %0d 0", cyc, c1, LAT + 2); end
      shift_out(got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL readback_chain: got %h required %h", got, e); end
   endtask
   task automatic test_collisions();
      int cyc; logic c1; logic [53:0] got, e;
      bus.scan_en = 1'b1; bus.sram_load = 1'b1;
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.sram_csb !== 1'b1) begin n_fail++; $display("FAIL load_with_scan: got busy=%b csb=%b required 0 1", bus.busy, bus.sram_csb); end
      bus.scan_en = 1'b0; bus.sram_load = 1'b0;
      tick();
      bus.global_csb = 1'b1; bus.sram_load = 1'b1;
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.sram_csb !== 1'b1) begin n_fail++; $display("FAIL load_global_csb: got busy=%b csb=%b required 0 1", bus.busy, bus.sram_csb); end
      tick();
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL load_global_csb_hold: got busy=%b required 0", bus.busy); end
      bus.global_csb = 1'b0; bus.sram_load = 1'b0;
      tick();
      shift_in(pk(16'h0010, 32'h0, 4'hF, 1'b0, 1'b1));
      access(1'b0, cyc, c1);
      n_checks++;
      if (c1 !== 1'b1 || cyc !== LAT + 2) begin n_fail++; $display("FAIL csb_bit_packet: got csb=%b cyc=%0d required 1 %0d", c1, cyc, LAT + 2); end
      shift_in(pk(16'h0010, 32'hDEADBEEF, 4'h0, 1'b1, 1'b0));
      exp_q.push_back(pk(16'h0010, 32'hDEADBEEF, 4'h0, 1'b1, 1'b0));
      access(1'b1, cyc, c1);
      n_checks++;
      if (cyc !== LAT + 2) begin n_fail++; $display("FAIL jam_latency: got %0d required %0d", cyc, LAT + 2); end
      shift_out(got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL jam_chain: got %h required %h", got, e); end
   endtask
   task automatic test_partial_mask();
      int cyc; logic c1; logic [53:0] got, e;
      shift_in(pk(16'h0010, 32'h11223344, 4'h3, 1'b0, 1'b0));
      access(1'b0, cyc, c1);
      shift_in(pk(16'h0010, 32'hDEAD3344, 4'h0, 1'b1, 1'b0));
      exp_q.push_back(pk(16'h0010, 32'hDEAD3344, 4'h0, 1'b1, 1'b0));
      access(1'b0, cyc, c1);
      shift_out(got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL partial_mask: got %h required %h", got, e); end
      n_checks++;
      if (bus.mismatch !== 1'b0) begin n_fail++; $display("FAIL mismatch_clean: got %b required 0", bus.mismatch); end
   endtask
   task automatic test_check();
      int cyc; logic c1; logic [53:0] got, e; logic exp_mis;
`ifdef SRAM_SCAN_CHECK_EN
      exp_mis = 1'b1;
`else
      exp_mis = 1'b0;
`endif
      shift_in(pk(16'h0010, 32'h0, 4'h0, 1'b1, 1'b0));
      exp_q.push_back(pk(16'h0010, 32'hDEAD3344, 4'h0, 1'b1, 1'b0));
      access(1'b0, cyc, c1);
      n_checks++;
      if (bus.mismatch !== exp_mis) begin n_fail++; $display("FAIL mismatch_bad_read: got %b required %b", bus.mismatch, exp_mis); end
      shift_out(got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL bad_read_chain: got %h required %h", got, e); end
      shift_in(pk(16'h0010, 32'hDEAD3344, 4'h0, 1'b1, 1'b0));
      access(1'b0, cyc, c1);
      n_checks++;
      if (bus.mismatch !== exp_mis) begin n_fail++; $display("FAIL mismatch_sticky: got %b required %b", bus.mismatch, exp_mis); end
   endtask
   initial begin
      test_reset();
      test_write();
      test_readback();
      test_collisions();
      test_partial_mask();
      test_check();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
